// File: rtl/scpad_req_arbiter.sv
// Scratchpad request arbiter: picks one of two requesters (FE, BE) per cycle,
// issues the winner to the banks, and routes read data / write completions
// back to the issuer after a fixed LAT-cycle pipeline.
// Optional build macro: SCPAD_ARB_STARVE_EN enables the FE anti-starvation
// counter; without it, BE always has strict priority over FE.

package scpad_arb_pkg;
   typedef logic [31:0] scpad_data_t;

   typedef struct packed {
      logic [3:0] bank;
      logic [9:0] addr;
   } xbar_desc_t;

   typedef enum logic {
      SRC_FE = 1'b0,
      SRC_BE = 1'b1
   } req_src_t;

   typedef struct packed {
      logic        valid;
      req_src_t    src;
      xbar_desc_t  xbar;
      scpad_data_t wdata;
   } sel_wr_req_t;

   typedef struct packed {
      logic       valid;
      req_src_t   src;
      xbar_desc_t xbar;
   } sel_rd_req_t;

   typedef struct packed {
      logic        complete;
      scpad_data_t rdata;
   } rd_res_t;

   typedef struct packed {
      logic complete;
   } wr_res_t;
endpackage

module scpad_req_arbiter
   import scpad_arb_pkg::*;
#(
   parameter int unsigned LAT        = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fe_req_valid,
   input  logic        be_req_valid,
   input  logic        fe_req_write,
   input  logic        be_req_write,
   input  xbar_desc_t  fe_req_xbar,
   input  xbar_desc_t  be_req_xbar,
   input  scpad_data_t fe_req_wdata,
   input  scpad_data_t be_req_wdata,
   output logic        fe_req_ready,
   output logic        be_req_ready,
   output sel_wr_req_t sel_wr_req,
   output sel_rd_req_t sel_rd_req,
   input  scpad_data_t bank_rdata,
   output rd_res_t     fe_rd_res,
   output rd_res_t     be_rd_res,
   output wr_res_t     fe_wr_res,
   output wr_res_t     be_wr_res
);

   typedef struct packed {
      logic     valid;
      logic     write;
      req_src_t src;
   } tag_t;

   if (LAT < 1 || STARVE_MAX < 1) begin : g_param_check
      $error("scpad_req_arbiter: LAT and STARVE_MAX must both be >= 1");
   end

   logic        fe_grant;
   logic        be_grant;
   logic        win_write;
   req_src_t    win_src;
   xbar_desc_t  win_xbar;
   scpad_data_t win_wdata;
   tag_t        grant_tag;
   tag_t        tags [LAT];
   tag_t        tail;

`ifdef SCPAD_ARB_STARVE_EN
   localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;
   logic          starve_hit;

   // FE has lost STARVE_MAX times in a row and is still asking: force it through
   always_comb begin
      starve_hit = fe_req_valid && (starve_cnt == CW'(STARVE_MAX));
   end

   // Grant: BE first unless the starvation override fires; nothing during reset
   always_comb begin
      fe_grant = 1'b0;
      be_grant = 1'b0;
      if (!rst) begin
         if (be_req_valid && !starve_hit) begin
            be_grant = 1'b1;
         end else if (fe_req_valid) begin
            fe_grant = 1'b1;
         end
      end
   end

   // Count consecutive FE losses to BE; any FE grant or FE withdrawal restarts it
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!fe_req_valid || fe_grant) begin
         starve_cnt <= '0;
      end else if (be_grant && (starve_cnt != CW'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   // Grant: strict BE-over-FE priority; nothing during reset
   always_comb begin
      fe_grant = 1'b0;
      be_grant = 1'b0;
      if (!rst) begin
         if (be_req_valid) begin
            be_grant = 1'b1;
         end else if (fe_req_valid) begin
            fe_grant = 1'b1;
         end
      end
   end
`endif

   assign fe_req_ready = fe_grant;
   assign be_req_ready = be_grant;

   // Mux the winning requester's fields
   always_comb begin
      win_src   = be_grant ? SRC_BE : SRC_FE;
      win_write = be_grant ? be_req_write : fe_req_write;
      win_xbar  = be_grant ? be_req_xbar  : fe_req_xbar;
      win_wdata = be_grant ? be_req_wdata : fe_req_wdata;
   end

   // Drive the bank-side request and the tag that follows it down the pipe
   always_comb begin
      sel_wr_req = '0;
      sel_rd_req = '0;
      grant_tag  = '0;
      if (fe_grant || be_grant) begin
         grant_tag.valid = 1'b1;
         grant_tag.write = win_write;
         grant_tag.src   = win_src;
         if (win_write) begin
            sel_wr_req.valid = 1'b1;
            sel_wr_req.src   = win_src;
            sel_wr_req.xbar  = win_xbar;
            sel_wr_req.wdata = win_wdata;
         end else begin
            sel_rd_req.valid = 1'b1;
            sel_rd_req.src   = win_src;
            sel_rd_req.xbar  = win_xbar;
         end
      end
   end

   // Tag pipeline matching the bank latency; reset drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            tags[i] <= '0;
         end
      end else begin
         tags[0] <= grant_tag;
         for (int unsigned i = 1; i < LAT; i++) begin
            tags[i] <= tags[i-1];
         end
      end
   end

   // Oldest tag lines up with bank_rdata this cycle
   always_comb begin
      tail = tags[LAT-1];
   end

   // Route the completion to its issuer; suppressed while reset is asserted
   always_comb begin
      fe_rd_res = '0;
      be_rd_res = '0;
      fe_wr_res = '0;
      be_wr_res = '0;
      if (!rst && tail.valid) begin
         if (tail.write) begin
            if (tail.src == SRC_FE) begin
               fe_wr_res.complete = 1'b1;
            end else begin
               be_wr_res.complete = 1'b1;
            end
         end else begin
            if (tail.src == SRC_FE) begin
               fe_rd_res.complete = 1'b1;
               fe_rd_res.rdata    = bank_rdata;
            end else begin
               be_rd_res.complete = 1'b1;
               be_rd_res.rdata    = bank_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_scpad_req_arbiter.sv
// Self-checking bench for scpad_req_arbiter (LAT = 2, STARVE_MAX = 4).
// Grant expectations are per-vector constants; response expectations come
// from a scoreboard queue filled at issue time and drained LAT cycles later.
module tb_scpad_req_arbiter;
   import scpad_arb_pkg::*;

   localparam int unsigned LAT        = 2;
   localparam int unsigned STARVE_MAX = 4;
`ifdef SCPAD_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   localparam int unsigned G_NONE = 0;
   localparam int unsigned G_FE   = 1;
   localparam int unsigned G_BE   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        fe_req_valid, be_req_valid;
   logic        fe_req_write, be_req_write;
   xbar_desc_t  fe_req_xbar, be_req_xbar;
   scpad_data_t fe_req_wdata, be_req_wdata;
   logic        fe_req_ready, be_req_ready;
   sel_wr_req_t sel_wr_req;
   sel_rd_req_t sel_rd_req;
   scpad_data_t bank_rdata;
   rd_res_t     fe_rd_res, be_rd_res;
   wr_res_t     fe_wr_res, be_wr_res;

   always #5 clk = ~clk;

   scpad_req_arbiter #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk          (clk),
      .rst          (rst),
      .fe_req_valid (fe_req_valid),
      .be_req_valid (be_req_valid),
      .fe_req_write (fe_req_write),
      .be_req_write (be_req_write),
      .fe_req_xbar  (fe_req_xbar),
      .be_req_xbar  (be_req_xbar),
      .fe_req_wdata (fe_req_wdata),
      .be_req_wdata (be_req_wdata),
      .fe_req_ready (fe_req_ready),
      .be_req_ready (be_req_ready),
      .sel_wr_req   (sel_wr_req),
      .sel_rd_req   (sel_rd_req),
      .bank_rdata   (bank_rdata),
      .fe_rd_res    (fe_rd_res),
      .be_rd_res    (be_rd_res),
      .fe_wr_res    (fe_wr_res),
      .be_wr_res    (be_wr_res)
   );

   typedef struct {
      logic        rst;
      logic        fe_v;
      logic        fe_w;
      logic        be_v;
      logic        be_w;
      int unsigned g;
   } vec_t;

   typedef struct {
      int unsigned due;
      logic        is_fe;
      logic        write;
   } exp_t;

   exp_t        sbq[$];
   vec_t        tbl[$];
   int unsigned cyc   = 0;
   int unsigned total = 0;
   int unsigned bad   = 0;

   // Bank model: a distinct 0xA5A5-tagged word every cycle
   assign bank_rdata = {16'hA5A5, cyc[15:0]};

   function automatic vec_t mk(logic r, logic fv, logic fw, logic bv, logic bw, int unsigned g);
      vec_t v;
      v.rst = r; v.fe_v = fv; v.fe_w = fw; v.be_v = bv; v.be_w = bw; v.g = g;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check_grant(input vec_t v);
      sel_wr_req_t ew;
      sel_rd_req_t er;
      req_src_t    s;
      logic        w;
      xbar_desc_t  xb;
      scpad_data_t wd;
      ew = '0;
      er = '0;
      if (v.g != G_NONE) begin
         s  = (v.g == G_FE) ? SRC_FE : SRC_BE;
         w  = (v.g == G_FE) ? v.fe_w : v.be_w;
         xb = (v.g == G_FE) ? fe_req_xbar : be_req_xbar;
         wd = (v.g == G_FE) ? fe_req_wdata : be_req_wdata;
         if (w) begin
            ew.valid = 1'b1; ew.src = s; ew.xbar = xb; ew.wdata = wd;
         end else begin
            er.valid = 1'b1; er.src = s; er.xbar = xb;
         end
         sbq.push_back('{due: cyc + LAT, is_fe: (v.g == G_FE), write: w});
      end
      check("fe_ready", 64'(fe_req_ready), 64'(v.g == G_FE));
      check("be_ready", 64'(be_req_ready), 64'(v.g == G_BE));
      check("sel_wr", 64'(sel_wr_req), 64'(ew));
      check("sel_rd", 64'(sel_rd_req), 64'(er));
   endtask

   task automatic check_res();
      rd_res_t     efr, ebr;
      wr_res_t     efw, ebw;
      exp_t        e;
      logic [31:0] pat;
      efr = '0; ebr = '0; efw = '0; ebw = '0;
      pat = {16'hA5A5, cyc[15:0]};
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         if (e.write) begin
            if (e.is_fe) efw.complete = 1'b1;
            else         ebw.complete = 1'b1;
         end else begin
            if (e.is_fe) begin efr.complete = 1'b1; efr.rdata = pat; end
            else         begin ebr.complete = 1'b1; ebr.rdata = pat; end
         end
      end
      check("fe_rd_res", 64'(fe_rd_res), 64'(efr));
      check("be_rd_res", 64'(be_rd_res), 64'(ebr));
      check("fe_wr_res", 64'(fe_wr_res), 64'(efw));
      check("be_wr_res", 64'(be_wr_res), 64'(ebw));
   endtask

   // One cycle: drive, compare at the falling edge, then let the rising edge consume it
   task automatic apply(input vec_t v);
      rst          = v.rst;
      fe_req_valid = v.fe_v;
      fe_req_write = v.fe_w;
      be_req_valid = v.be_v;
      be_req_write = v.be_w;
      fe_req_xbar  = xbar_desc_t'($urandom);
      be_req_xbar  = xbar_desc_t'($urandom);
      fe_req_wdata = $urandom;
      be_req_wdata = $urandom;
      if (v.rst) sbq.delete();
      @(negedge clk);
      check_grant(v);
      check_res();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      fe_req_valid = 1'b0; be_req_valid = 1'b0;
      fe_req_write = 1'b0; be_req_write = 1'b0;
      fe_req_xbar = '0; be_req_xbar = '0;
      fe_req_wdata = '0; be_req_wdata = '0;

      //               rst fe_v fe_w be_v be_w grant
      tbl.push_back(mk(1, 1, 0, 1, 0, G_NONE));  // reset blocks pending requests
      tbl.push_back(mk(1, 0, 0, 0, 0, G_NONE));
      tbl.push_back(mk(0, 0, 0, 0, 0, G_NONE));
      tbl.push_back(mk(0, 1, 0, 0, 0, G_FE));    // lone FE read, lands 2 cycles later
      tbl.push_back(mk(0, 0, 0, 0, 0, G_NONE));
      tbl.push_back(mk(0, 0, 0, 0, 0, G_NONE));
      tbl.push_back(mk(0, 1, 1, 0, 0, G_FE));    // back-to-back mixed traffic
      tbl.push_back(mk(0, 0, 0, 1, 0, G_BE));
      tbl.push_back(mk(0, 0, 0, 1, 1, G_BE));
      tbl.push_back(mk(0, 1, 0, 1, 1, G_BE));    // contention: BE wins
      tbl.push_back(mk(0, 1, 1, 1, 0, G_BE));
      tbl.push_back(mk(0, 0, 0, 1, 1, G_BE));
      tbl.push_back(mk(0, 1, 0, 0, 0, G_FE));    // alternating FE read / BE write
      tbl.push_back(mk(0, 0, 0, 1, 1, G_BE));
      tbl.push_back(mk(0, 1, 0, 0, 0, G_FE));
      tbl.push_back(mk(0, 0, 0, 1, 1, G_BE));
      tbl.push_back(mk(0, 1, 1, 0, 0, G_FE));
      tbl.push_back(mk(0, 1, 0, 1, 0, G_BE));
      tbl.push_back(mk(0, 0, 0, 0, 0, G_NONE));
      tbl.push_back(mk(0, 0, 0, 0, 0, G_NONE));

      @(posedge clk);
      #1;
      foreach (tbl[i]) apply(tbl[i]);

      // Sustained contention for 10 cycles
      apply(mk(0, 0, 0, 0, 0, G_NONE));
      for (int i = 0; i < 10; i++) begin
         apply(mk(0, 1, 1'($urandom), 1, 1'($urandom),
                  (STARVE && (i % 5 == 4)) ? G_FE : G_BE));
      end
      apply(mk(0, 0, 0, 0, 0, G_NONE));

      // FE loses 3 times, withdraws, then must lose 4 more before its override
      for (int i = 0; i < 3; i++) apply(mk(0, 1, 0, 1, 1, G_BE));
      apply(mk(0, 0, 0, 1, 0, G_BE));
      for (int i = 0; i < 5; i++) begin
         apply(mk(0, 1, 0, 1, 0, (STARVE && i == 4) ? G_FE : G_BE));
      end
      apply(mk(0, 0, 0, 0, 0, G_NONE));
      apply(mk(0, 0, 0, 0, 0, G_NONE));

      // Reset lands while two reads are in flight: neither may complete
      apply(mk(0, 1, 0, 0, 0, G_FE));
      apply(mk(0, 0, 0, 1, 0, G_BE));
      apply(mk(1, 1, 0, 1, 0, G_NONE));
      apply(mk(0, 0, 0, 0, 0, G_NONE));
      apply(mk(0, 0, 0, 0, 0, G_NONE));
      apply(mk(0, 1, 0, 0, 0, G_FE));
      for (int i = 0; i < LAT + 2; i++) apply(mk(0, 0, 0, 0, 0, G_NONE));

      check("sb_drained", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
